// File: rtl/sound_mailbox_ctrl.sv
// 68k<->6502 sound mailbox: two byte FIFOs, NMI sequencer toward the 6502,
// level interrupt toward the 68k and sticky overrun tracking.

// Byte FIFO with registered status flags, underflow read value and sticky overrun.
module sound_mailbox_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  input  logic       ovr_clr,
  output logic [7:0] rdata,
  output logic       nonempty,
  output logic       full,
  output logic       ovr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic          is_empty;
  logic          is_full;
  logic          pop_ok;
  logic          push_ok;
  logic          ovr_set;
  logic          full_nxt;

  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot first, so a push into a full FIFO that pops too is accepted.
  assign pop_ok  = pop && !is_empty;
  assign push_ok = push && (!is_full || pop_ok);
  assign ovr_set = push && is_full && !pop_ok;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (pop_ok) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
    end
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end
  end

  assign full_nxt = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdata    <= 8'h00;
      nonempty <= 1'b0;
      full     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      nonempty <= (wr_ptr_nxt != rd_ptr_nxt);
      full     <= full_nxt;
      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
      if (pop) begin
        rdata <= pop_ok ? mem[rd_ptr[AW-1:0]] : 8'hFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

module sound_mailbox_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NMI_PULSE = 8,
  parameter int unsigned NMI_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       snd_rst,
  input  logic       m68k_wr,
  input  logic [7:0] m68k_wdata,
  input  logic       m68k_rd,
  output logic [7:0] m68k_rdata,
  input  logic       snd_wr,
  input  logic [7:0] snd_wdata,
  input  logic       snd_rd,
  output logic [7:0] snd_rdata,
  output logic       ctrl_68kBUF,
  output logic       ctrl_SNDBUF,
  output logic       full_68k,
  output logic       full_snd,
  output logic       ovr_68k,
  output logic       ovr_snd,
  input  logic       ovr_clr,
  output logic       SNDNMI_b,
  output logic       SNDINT_b
);

  localparam int unsigned CMAX = (NMI_PULSE > NMI_GAP) ? NMI_PULSE : NMI_GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    NMI_IDLE,
    NMI_PULSE_ST,
    NMI_GAP_ST
  } nmi_state_t;

  nmi_state_t    state;
  nmi_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          nmi_b_nxt;

  // 68k -> 6502 direction
  sound_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo_68k (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (m68k_wr),
    .wdata    (m68k_wdata),
    .pop      (snd_rd),
    .ovr_clr  (ovr_clr),
    .rdata    (snd_rdata),
    .nonempty (ctrl_68kBUF),
    .full     (full_68k),
    .ovr      (ovr_68k)
  );

  // 6502 -> 68k direction; sound reset flushes it and discards a concurrent write
  sound_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo_snd (
    .clk      (clk),
    .rst      (rst),
    .flush    (snd_rst),
    .push     (snd_wr && !snd_rst),
    .wdata    (snd_wdata),
    .pop      (m68k_rd),
    .ovr_clr  (ovr_clr),
    .rdata    (m68k_rdata),
    .nonempty (ctrl_SNDBUF),
    .full     (full_snd),
    .ovr      (ovr_snd)
  );

  // 68k interrupt lags the buffer flag by a cycle; a sound reset releases it at once
  always_ff @(posedge clk) begin
    if (rst || snd_rst) begin
      SNDINT_b <= 1'b1;
    end else begin
      SNDINT_b <= ~ctrl_SNDBUF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NMI_IDLE;
      cnt      <= '0;
      SNDNMI_b <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      SNDNMI_b <= nmi_b_nxt;
    end
  end

  // NMI sequencer: fixed-width low pulse, then a guaranteed high gap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nmi_b_nxt = 1'b1;
    case (state)
      NMI_IDLE: begin
        if (ctrl_68kBUF) begin
          state_nxt = NMI_PULSE_ST;
          cnt_nxt   = '0;
        end
      end
      NMI_PULSE_ST: begin
        if (cnt == CW'(NMI_PULSE - 1)) begin
          state_nxt = NMI_GAP_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      NMI_GAP_ST: begin
        if (cnt == CW'(NMI_GAP - 1)) begin
          state_nxt = NMI_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = NMI_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    nmi_b_nxt = (state_nxt != NMI_PULSE_ST);
  end

endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
// Self-checking bench for sound_mailbox_ctrl: queue-based FIFO model plus a
// read-data scoreboard, with directed NMI timing checks.
module tb_sound_mailbox_ctrl;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NMI_PULSE = 8;
  localparam int unsigned NMI_GAP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       snd_rst = 1'b0;
  logic       m68k_wr = 1'b0;
  logic [7:0] m68k_wdata = 8'h00;
  logic       m68k_rd = 1'b0;
  logic [7:0] m68k_rdata;
  logic       snd_wr = 1'b0;
  logic [7:0] snd_wdata = 8'h00;
  logic       snd_rd = 1'b0;
  logic [7:0] snd_rdata;
  logic       ctrl_68kBUF, ctrl_SNDBUF, full_68k, full_snd, ovr_68k, ovr_snd;
  logic       ovr_clr = 1'b0;
  logic       SNDNMI_b, SNDINT_b;

  sound_mailbox_ctrl #(.DEPTH(DEPTH), .NMI_PULSE(NMI_PULSE), .NMI_GAP(NMI_GAP)) dut (
    .clk(clk), .rst(rst), .snd_rst(snd_rst),
    .m68k_wr(m68k_wr), .m68k_wdata(m68k_wdata), .m68k_rd(m68k_rd), .m68k_rdata(m68k_rdata),
    .snd_wr(snd_wr), .snd_wdata(snd_wdata), .snd_rd(snd_rd), .snd_rdata(snd_rdata),
    .ctrl_68kBUF(ctrl_68kBUF), .ctrl_SNDBUF(ctrl_SNDBUF),
    .full_68k(full_68k), .full_snd(full_snd), .ovr_68k(ovr_68k), .ovr_snd(ovr_snd),
    .ovr_clr(ovr_clr), .SNDNMI_b(SNDNMI_b), .SNDINT_b(SNDINT_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] sb_snd[$];
  logic [7:0] sb_m68k[$];
  logic [7:0] last_snd  = 8'h00;
  logic [7:0] last_m68k = 8'h00;
  logic       m_ovr_a = 1'b0;
  logic       m_ovr_b = 1'b0;
  logic       m_int   = 1'b1;
  logic       nmi_prev = 1'b1;
  int         nmi_fall[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Update the model from the driven inputs, clock once, then compare.
  task automatic tick();
    logic int_nxt;
    int_nxt = (rst || snd_rst) ? 1'b1 : (q_b.size() == 0);
    if (rst) begin
      q_a.delete(); q_b.delete(); sb_snd.delete(); sb_m68k.delete();
      m_ovr_a = 1'b0; m_ovr_b = 1'b0;
      last_snd = 8'h00; last_m68k = 8'h00;
    end else begin
      if (ovr_clr) begin
        m_ovr_a = 1'b0; m_ovr_b = 1'b0;
      end
      if (snd_rd) sb_snd.push_back(q_a.size() > 0 ? q_a.pop_front() : 8'hFF);
      if (m68k_wr) begin
        if (q_a.size() < DEPTH) q_a.push_back(m68k_wdata);
        else m_ovr_a = 1'b1;
      end
      if (m68k_rd) sb_m68k.push_back(q_b.size() > 0 ? q_b.pop_front() : 8'hFF);
      if (snd_rst) q_b.delete();
      else if (snd_wr) begin
        if (q_b.size() < DEPTH) q_b.push_back(snd_wdata);
        else m_ovr_b = 1'b1;
      end
    end
    m_int = int_nxt;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0; snd_rst = 1'b0; m68k_wr = 1'b0; m68k_rd = 1'b0;
    snd_wr = 1'b0; snd_rd = 1'b0; ovr_clr = 1'b0;
    if (sb_snd.size() > 0) last_snd = sb_snd.pop_front();
    if (sb_m68k.size() > 0) last_m68k = sb_m68k.pop_front();
    chk("snd_rdata", snd_rdata, last_snd);
    chk("m68k_rdata", m68k_rdata, last_m68k);
    chk("ctrl_68kBUF", ctrl_68kBUF, q_a.size() != 0);
    chk("ctrl_SNDBUF", ctrl_SNDBUF, q_b.size() != 0);
    chk("full_68k", full_68k, q_a.size() == DEPTH);
    chk("full_snd", full_snd, q_b.size() == DEPTH);
    chk("ovr_68k", ovr_68k, m_ovr_a);
    chk("ovr_snd", ovr_snd, m_ovr_b);
    chk("SNDINT_b", SNDINT_b, m_int);
    if (nmi_prev && !SNDNMI_b) nmi_fall.push_back(cyc);
    nmi_prev = SNDNMI_b;
  endtask

  initial begin
    logic [7:0] vals[5];
    logic found;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;

    // reset then idle
    rst = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_nmi", SNDNMI_b, 1'b1);
      chk("idle_int", SNDINT_b, 1'b1);
    end

    // write path: NMI low two cycles after the first write strobe, for NMI_PULSE cycles
    m68k_wr = 1'b1; m68k_wdata = 8'hA5; tick();
    chk("nmi_not_yet", SNDNMI_b, 1'b1);
    m68k_wr = 1'b1; m68k_wdata = 8'h3C; tick();
    for (int i = 0; i < NMI_PULSE; i++) begin
      chk("nmi_low", SNDNMI_b, 1'b0);
      tick();
    end
    chk("nmi_end", SNDNMI_b, 1'b1);
    snd_rd = 1'b1; tick();
    chk("rd_a5", snd_rdata, 8'hA5);
    snd_rd = 1'b1; tick();
    chk("rd_3c", snd_rdata, 8'h3C);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_renmi", SNDNMI_b, 1'b1);
    end

    // overrun on the 6502 -> 68k FIFO
    for (int i = 0; i < 5; i++) begin
      snd_wr = 1'b1; snd_wdata = vals[i]; tick();
      if (i == 3) chk("full_after_4", full_snd, 1'b1);
    end
    chk("ovr_after_5", ovr_snd, 1'b1);
    for (int i = 0; i < 5; i++) begin
      m68k_rd = 1'b1; tick();
    end
    chk("underflow_ff", m68k_rdata, 8'hFF);
    ovr_clr = 1'b1; tick();
    chk("ovr_cleared", ovr_snd, 1'b0);

    // simultaneous push and pop on a full FIFO
    for (int i = 0; i < DEPTH; i++) begin
      snd_wr = 1'b1; snd_wdata = 8'(8'h61 + i); tick();
    end
    snd_wr = 1'b1; snd_wdata = 8'h77; m68k_rd = 1'b1; tick();
    chk("sim_no_ovr", ovr_snd, 1'b0);
    chk("sim_full", full_snd, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      m68k_rd = 1'b1; tick();
    end
    chk("sim_last_77", m68k_rdata, 8'h77);
    for (int i = 0; i < 20; i++) tick();

    // re-NMI when a byte stays unread through the gap
    nmi_fall.delete();
    m68k_wr = 1'b1; m68k_wdata = 8'h5A; tick();
    for (int i = 0; i < 30; i++) tick();
    chk("renmi_seen", nmi_fall.size() >= 2, 1'b1);
    if (nmi_fall.size() >= 2)
      chk("renmi_period", 8'(nmi_fall[1] - nmi_fall[0]), 8'(NMI_PULSE + NMI_GAP + 1));
    snd_rd = 1'b1; tick();
    for (int i = 0; i < 20; i++) tick();

    // sound reset with two bytes in each FIFO
    m68k_wr = 1'b1; m68k_wdata = 8'h01; snd_wr = 1'b1; snd_wdata = 8'h81; tick();
    m68k_wr = 1'b1; m68k_wdata = 8'h02; snd_wr = 1'b1; snd_wdata = 8'h82; tick();
    tick();
    chk("pre_int_low", SNDINT_b, 1'b0);
    snd_rst = 1'b1; tick();
    chk("srst_sndbuf", ctrl_SNDBUF, 1'b0);
    chk("srst_int", SNDINT_b, 1'b1);
    chk("srst_68kbuf", ctrl_68kBUF, 1'b1);

    // reset in the middle of an NMI pulse
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (!SNDNMI_b) found = 1'b1;
      else tick();
    end
    chk("nmi_before_rst", SNDNMI_b, 1'b0);
    rst = 1'b1; tick();
    chk("rst_nmi_high", SNDNMI_b, 1'b1);
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
